// File: rtl/conv_mul_arbiter.sv
// rtl/conv_mul_arbiter.sv - shared radix-2 Booth serial multiplier with two-requester round-robin arbiter
// Optional feature macro: CONV_MUL_ZERO_SKIP_EN (zero operand completes in one cycle)
module conv_mul_arbiter #(
  parameter int DATA_W = 20,
  parameter int COEF_W = 17
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [DATA_W-1:0]        req0_data,
  input  logic [COEF_W-1:0]        req0_coef,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [DATA_W-1:0]        req1_data,
  input  logic [COEF_W-1:0]        req1_coef,
  output logic                     req1_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_id,
  output logic [DATA_W+COEF_W-1:0] res_product,
  output logic                     busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int REG_W  = PROD_W + 1;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [REG_W-1:0]   prod;
  logic [COEF_W-1:0]  coef;
  logic [CNT_W-1:0]   step;
  logic               last_grant;
  logic               id;
  logic               grant0, grant1, accept;
  logic               sel1;
  logic [DATA_W-1:0]  acc_data;
  logic [COEF_W-1:0]  acc_coef;
  logic               zero_op;
  logic               last_step;
  logic [COEF_W:0]    upper_ext, coef_ext, booth_sum;

  // Operand mux follows the arbitration winner; kept independent of the FSM block.
  assign sel1     = req1_valid && (!req0_valid || !last_grant);
  assign acc_data = sel1 ? req1_data : req0_data;
  assign acc_coef = sel1 ? req1_coef : req0_coef;

`ifdef CONV_MUL_ZERO_SKIP_EN
  assign zero_op = (acc_data == '0) || (acc_coef == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign last_step = (step == CNT_W'(DATA_W - 1));
  assign accept    = grant0 || grant1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          grant0 = req0_valid && (!req1_valid || last_grant);
          grant1 = req1_valid && (!req0_valid || !last_grant);
        end
        if (grant0 || grant1) state_next = zero_op ? DONE : RUN;
      end
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The add is one bit wider than the accumulator so a most-negative coef cannot overflow;
  // the extra bit becomes the sign shifted back into the register.
  assign upper_ext = {prod[REG_W-1], prod[REG_W-1 -: COEF_W]};
  assign coef_ext  = {coef[COEF_W-1], coef};

  always_comb begin
    booth_sum = upper_ext;
    case (prod[1:0])
      2'b01:   booth_sum = upper_ext + coef_ext;
      2'b10:   booth_sum = upper_ext - coef_ext;
      default: booth_sum = upper_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod       <= '0;
      coef       <= '0;
      step       <= '0;
      last_grant <= 1'b1;
      id         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            coef       <= acc_coef;
            id         <= grant1;
            last_grant <= grant1;
            step       <= '0;
            prod       <= zero_op ? '0 : {{COEF_W{1'b0}}, acc_data, 1'b0};
          end
        end
        RUN: begin
          prod <= {booth_sum, prod[DATA_W:1]};
          step <= step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign res_valid   = (state == DONE);
  assign res_id      = id;
  assign res_product = prod[REG_W-1:1];
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_conv_mul_arbiter.sv
// tb/tb_conv_mul_arbiter.sv - scoreboard bench for conv_mul_arbiter
// Honours CONV_MUL_ZERO_SKIP_EN for the zero-operand latency expectation.
module tb_conv_mul_arbiter;
  localparam int DATA_W = 20;
  localparam int COEF_W = 17;
  localparam int PW = DATA_W + COEF_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic [COEF_W-1:0] req0_coef, req1_coef;
  logic              req0_ready, req1_ready;
  logic              res_valid, res_ready, res_id, busy;
  logic [PW-1:0]     res_product;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  logic [PW:0] exp_q[$];

  conv_mul_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_coef(req0_coef), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_coef(req1_coef), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_product(res_product),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor: pops one expectation for each result handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_ready || req1_ready) begin
        check("ready_mutex", 64'(req0_ready && req1_ready), 64'd0);
        check("ready_only_idle", 64'(busy), 64'd0);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_result: got id %0d product %h expected none", res_id, res_product);
        end else begin
          logic [PW:0] e;
          e = exp_q.pop_front();
          check("res_id", 64'(res_id), 64'(e[PW]));
          check("res_product", 64'(res_product), 64'(e[PW-1:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit v, input logic [DATA_W-1:0] d, input logic [COEF_W-1:0] c);
    if (id) begin req1_valid = v; req1_data = d; req1_coef = c; end
    else    begin req0_valid = v; req0_data = d; req0_coef = c; end
  endtask

  task automatic do_op(input bit id, input logic [DATA_W-1:0] d, input logic [COEF_W-1:0] c,
                       input logic [PW-1:0] exp, input int exp_lat);
    bit got;
    int n;
    set_req(id, 1'b1, d, c);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin got = 1; break; end
    end
    check("grant", 64'(got), 64'd1);
    exp_q.push_back({id, exp});
    tick();
    set_req(id, 1'b0, d, c);
    got = 0;
    n = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid) begin got = 1; break; end
      n++;
    end
    check("res_valid_seen", 64'(got), 64'd1);
    check("latency", 64'(n), 64'(exp_lat));
    tick();
    @(negedge clk);
    check("idle_after_accept", 64'(busy), 64'd0);
    tick();
  endtask

  int zero_lat;
  bit got;
  bit gid[4];
  int gcyc[4];
  int ng;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
`ifdef CONV_MUL_ZERO_SKIP_EN
    zero_lat = 1;
`else
    zero_lat = DATA_W + 1;
`endif
    reset = 1'b1; res_ready = 1'b1;
    set_req(0, 1'b1, 20'd5, 17'd3);
    set_req(1, 1'b0, '0, '0);
    tick();
    @(negedge clk);
    check("ready_in_reset", 64'(req0_ready), 64'd0);
    tick();
    reset = 1'b0;
    set_req(0, 1'b0, '0, '0);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    check("rst_res_product", 64'(res_product), 64'd0);
    tick();

    do_op(0, 20'd1000,  17'h1FFFD, 37'h1F_FFFF_F448, DATA_W + 1);
    do_op(1, 20'h7FFFF, 17'h0FFFF, 37'h07_FFF7_0001, DATA_W + 1);
    do_op(0, 20'hFFFFF, 17'h10000, 37'h00_0001_0000, DATA_W + 1);
    do_op(1, 20'h80000, 17'h10000, 37'h08_0000_0000, DATA_W + 1);
    do_op(0, 20'h80000, 17'h0FFFF, 37'h18_0008_0000, DATA_W + 1);
    do_op(1, 20'd0,     17'h0A89E, 37'h0,            zero_lat);

    // Result held under back-pressure; contenders must see no grant.
    res_ready = 1'b0;
    set_req(0, 1'b1, 20'hFFFFB, 17'h00007);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req0_ready) begin got = 1; break; end
    end
    check("hold_grant", 64'(got), 64'd1);
    exp_q.push_back({1'b0, 37'h1F_FFFF_FFDD});
    tick();
    set_req(1, 1'b1, 20'd9, 17'd9);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid) begin got = 1; break; end
    end
    check("hold_res_valid_seen", 64'(got), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("hold_res_valid", 64'(res_valid), 64'd1);
      check("hold_res_id", 64'(res_id), 64'd0);
      check("hold_res_product", 64'(res_product), 64'(37'h1F_FFFF_FFDD));
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_no_ready", 64'(req0_ready || req1_ready), 64'd0);
    end
    tick();
    res_ready = 1'b1;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    tick();
    @(negedge clk);
    check("hold_release_idle", 64'(busy), 64'd0);
    check("hold_release_valid", 64'(res_valid), 64'd0);
    tick();

    // Reset mid-RUN; the in-flight result is dropped and the pointer returns to 1.
    set_req(0, 1'b1, 20'd123, 17'd456);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req0_ready) begin got = 1; break; end
    end
    check("midrun_grant", 64'(got), 64'd1);
    tick();
    set_req(0, 1'b0, '0, '0);
    repeat (9) tick();
    reset = 1'b1;
    set_req(1, 1'b1, 20'd1, 17'd1);
    @(negedge clk);
    check("midrun_ready_in_reset", 64'(req1_ready), 64'd0);
    tick();
    reset = 1'b0;
    set_req(1, 1'b0, '0, '0);
    @(negedge clk);
    check("midrun_busy", 64'(busy), 64'd0);
    check("midrun_res_valid", 64'(res_valid), 64'd0);
    check("midrun_res_product", 64'(res_product), 64'd0);
    tick();

    // Continuous tie: alternating grants, fixed spacing.
    set_req(0, 1'b1, 20'd3, 17'd5);
    set_req(1, 1'b1, 20'hFFFF9, 17'd9);
    ng = 0;
    for (int i = 0; i < 200 && ng < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        gid[ng] = req1_ready;
        gcyc[ng] = cyc;
        if (req1_ready) exp_q.push_back({1'b1, 37'h1F_FFFF_FFC1});
        else            exp_q.push_back({1'b0, 37'h00_0000_000F});
        ng++;
      end
    end
    tick();
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    check("tie_grant_count", 64'(ng), 64'd4);
    for (int k = 0; k < ng; k++) begin
      check("tie_grant_order", 64'(gid[k]), 64'(k % 2));
      if (k > 0) check("tie_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'(DATA_W + 2));
    end
    repeat (30) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
